tb_engine: RTL and testbench

TB_ENGINE -- requirements
Module: tb_engine

---
 rtl/tb_pkg.sv | 22 ++
 rtl/tb_out_pack.sv | 95 +++++++++
 rtl/tb_engine.sv | 150 +++++++++++++++
 tb/tb_tb_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tb_pkg.sv
// Shared definitions for the traceback engine.
//   - FSM state encoding (IDLE, RD, USE, FLUSH, DONE)
//   - Default SW / W_TB_LEN / W_OUT values
//   - Legal range of the active state width m
package tb_pkg;

    localparam int TB_SW_DEF       = 6;
    localparam int TB_W_TB_LEN_DEF = 6;
    localparam int TB_W_OUT_DEF    = 32;

    localparam int TB_M_MIN = 3;
    localparam int TB_M_MAX = TB_SW_DEF;

    typedef logic [2:0] tb_state_t;

    localparam tb_state_t S_IDLE  = 3'd0;
    localparam tb_state_t S_RD    = 3'd1;
    localparam tb_state_t S_USE   = 3'd2;
    localparam tb_state_t S_FLUSH = 3'd3;
    localparam tb_state_t S_DONE  = 3'd4;

endpackage

// File: rtl/tb_out_pack.sv
// Decoded-bit packer plus one-entry output register.
// Bits shift in at the LSB. The W_OUT-th bit moves the whole word straight
// into the output register; flush_i moves a partial word (upper bits zero)
// with out_last_o set.
// Build option: TB_ENGINE_REVERSE_EN bit-reverses each word within its
// out_nbits_o so the oldest decoded bit lands at the LSB.
// Ports:
//   clk_i, rst_sync_i        clock, synchronous active-high reset
//   shift_i, bit_i, last_i   push one decoded bit; last_i marks the final bit
//   flush_i                  emit the partial word (only when cnt_o != 0)
//   cnt_o                    bits currently held in the packer
//   slot_free_o              output register can accept a word this cycle
//   out_*                    valid/ready output stream
module tb_out_pack #(
    parameter  int W_OUT = 32,
    localparam int NBW   = $clog2(W_OUT) + 1
) (
    input  logic             clk_i,
    input  logic             rst_sync_i,
    input  logic             shift_i,
    input  logic             bit_i,
    input  logic             last_i,
    input  logic             flush_i,
    output logic [NBW-1:0]   cnt_o,
    output logic             slot_free_o,
    output logic [W_OUT-1:0] out_data_o,
    output logic [NBW-1:0]   out_nbits_o,
    output logic             out_last_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic [W_OUT-1:0] acc_q;
    logic [W_OUT-1:0] acc_sh;
    logic [W_OUT-1:0] full_word;
    logic [W_OUT-1:0] part_word;
    logic [NBW-1:0]   cnt_q;

    assign acc_sh = {acc_q[W_OUT-2:0], bit_i};

`ifdef TB_ENGINE_REVERSE_EN
    function automatic logic [W_OUT-1:0] rev_n(input logic [W_OUT-1:0] d,
                                               input logic [NBW-1:0]   n);
        logic [W_OUT-1:0] r;
        r = '0;
        for (int i = 0; i < W_OUT; i++)
            if (i < int'(n)) r[i] = d[int'(n) - 1 - i];
        return r;
    endfunction

    assign full_word = rev_n(acc_sh, NBW'(W_OUT));
    assign part_word = rev_n(acc_q, cnt_q);
`else
    assign full_word = acc_sh;
    assign part_word = acc_q;
`endif

    assign cnt_o       = cnt_q;
    // A word may be loaded in the same cycle the current one is taken.
    assign slot_free_o = !out_valid_o || out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_o  <= '0;
            out_nbits_o <= '0;
            out_last_o  <= 1'b0;
            out_valid_o <= 1'b0;
        end else begin
            if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
            if (shift_i) begin
                if (cnt_q == NBW'(W_OUT - 1)) begin
                    out_data_o  <= full_word;
                    out_nbits_o <= NBW'(W_OUT);
                    out_last_o  <= last_i;
                    out_valid_o <= 1'b1;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                end else begin
                    acc_q <= acc_sh;
                    cnt_q <= cnt_q + NBW'(1);
                end
            end else if (flush_i) begin
                out_data_o  <= part_word;
                out_nbits_o <= cnt_q;
                out_last_o  <= 1'b1;
                out_valid_o <= 1'b1;
                acc_q       <= '0;
                cnt_q       <= '0;
            end
        end
    end

endmodule

// File: rtl/tb_engine.sv
// Viterbi traceback engine. It walks the survivor memory backwards from
// start_addr_i, one step per RD/USE cycle pair. The first skip_len steps only
// advance the state. The next dec_len steps also emit the survivor bit into
// tb_out_pack.
// Build option: TB_ENGINE_REVERSE_EN (see tb_out_pack).
// Ports:
//   clk_i, rst_sync_i                 clock, synchronous active-high reset
//   start_i / start_rdy_o             segment start handshake (IDLE only)
//   cfg_m_i, start_state_i            active state width, initial state
//   start_addr_i, skip_len_i, dec_len_i
//                                     newest survivor address, warm-up and decoded steps
//   mem_rd_o, mem_addr_o, mem_rdata_i survivor read; data arrives one cycle later
//   out_data_o .. out_ready_i         packed output stream
//   busy_o, done_o                    activity flag, end-of-segment pulse
module tb_engine
    import tb_pkg::*;
#(
    parameter  int SW       = TB_SW_DEF,
    parameter  int W_TB_LEN = TB_W_TB_LEN_DEF,
    parameter  int W_OUT    = TB_W_OUT_DEF,
    localparam int MW       = $clog2(SW) + 1,
    localparam int NBW      = $clog2(W_OUT) + 1,
    localparam int CW       = W_TB_LEN + 2
) (
    input  logic                 clk_i,
    input  logic                 rst_sync_i,
    input  logic                 start_i,
    output logic                 start_rdy_o,
    input  logic [MW-1:0]        cfg_m_i,
    input  logic [SW-1:0]        start_state_i,
    input  logic [W_TB_LEN-1:0]  start_addr_i,
    input  logic [W_TB_LEN:0]    skip_len_i,
    input  logic [W_TB_LEN:0]    dec_len_i,
    output logic                 mem_rd_o,
    output logic [W_TB_LEN-1:0]  mem_addr_o,
    input  logic [(1<<SW)-1:0]   mem_rdata_i,
    output logic [W_OUT-1:0]     out_data_o,
    output logic [NBW-1:0]       out_nbits_o,
    output logic                 out_last_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [CW-1:0] STEP_MAX = CW'(1) << W_TB_LEN;

    tb_state_t           state;
    logic [MW-1:0]       m_q, m_in;
    logic [SW-1:0]       st_q, st_in, st_nxt, st_mask, b_top;
    logic [W_TB_LEN-1:0] addr_q;
    logic [CW-1:0]       step_q, total_q, skip_q, sum_in, total_in;
    logic                b_hold, b_vld, b;
    logic                dec_step, last_step, stall, step_go, pk_flush;
    logic [NBW-1:0]      pk_cnt;
    logic                slot_free;

    // Out-of-range m values are pulled into the legal window.
    function automatic logic [MW-1:0] clamp_m(input logic [MW-1:0] m);
        if (m < MW'(TB_M_MIN)) return MW'(TB_M_MIN);
        if (m > MW'(SW))       return MW'(SW);
        return m;
    endfunction

    assign m_in     = clamp_m(cfg_m_i);
    assign st_in    = start_state_i & ((SW'(1) << m_in) - SW'(1));
    assign sum_in   = CW'(skip_len_i) + CW'(dec_len_i);
    assign total_in = (sum_in > STEP_MAX) ? STEP_MAX : sum_in;

    // The survivor bit is held once the step stalls, so the memory does not
    // have to keep its read data stable across the stall.
    assign b       = b_vld ? b_hold : mem_rdata_i[st_q];
    assign st_mask = (SW'(1) << m_q) - SW'(1);
    assign b_top   = SW'(b) << (m_q - MW'(1));
    assign st_nxt  = ((st_q >> 1) | b_top) & st_mask;

    assign dec_step  = step_q >= skip_q;
    assign last_step = (step_q + CW'(1)) == total_q;
    // Stall only when this bit completes a word and the output slot is taken.
    assign stall     = (state == S_USE) && dec_step &&
                       (pk_cnt == NBW'(W_OUT - 1)) && !slot_free;
    assign step_go   = (state == S_USE) && !stall;
    assign pk_flush  = (state == S_FLUSH) && (pk_cnt != '0) && slot_free;

    assign start_rdy_o = (state == S_IDLE);
    assign busy_o      = (state != S_IDLE);
    assign mem_rd_o    = (state == S_RD);
    assign mem_addr_o  = mem_rd_o ? addr_q : '0;
    assign done_o      = (state == S_DONE);

    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            state   <= S_IDLE;
            m_q     <= '0;
            st_q    <= '0;
            addr_q  <= '0;
            step_q  <= '0;
            total_q <= '0;
            skip_q  <= '0;
            b_hold  <= 1'b0;
            b_vld   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    m_q     <= m_in;
                    st_q    <= st_in;
                    addr_q  <= start_addr_i;
                    step_q  <= '0;
                    total_q <= total_in;
                    skip_q  <= CW'(skip_len_i);
                    state   <= (total_in == '0) ? S_DONE : S_RD;
                end
                S_RD: state <= S_USE;
                S_USE: begin
                    if (stall) begin
                        b_hold <= b;
                        b_vld  <= 1'b1;
                    end else begin
                        st_q   <= st_nxt;
                        step_q <= step_q + CW'(1);
                        addr_q <= addr_q - W_TB_LEN'(1);
                        b_vld  <= 1'b0;
                        state  <= last_step ? S_FLUSH : S_RD;
                    end
                end
                // Leave once the packer is empty and the last word is taken.
                S_FLUSH: if (pk_cnt == '0 && slot_free) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    tb_out_pack #(.W_OUT(W_OUT)) u_pack (
        .clk_i       (clk_i),
        .rst_sync_i  (rst_sync_i),
        .shift_i     (step_go && dec_step),
        .bit_i       (b),
        .last_i      (last_step),
        .flush_i     (pk_flush),
        .cnt_o       (pk_cnt),
        .slot_free_o (slot_free),
        .out_data_o  (out_data_o),
        .out_nbits_o (out_nbits_o),
        .out_last_o  (out_last_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

endmodule

// File: tb/tb_tb_engine.sv
// Directed bench for tb_engine: a 32-bit output instance and an 8-bit output
// instance share one survivor memory model.
`timescale 1ns/1ps
module tb_tb_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start8, ready, ready8;
    logic [3:0]  cfg_m;
    logic [5:0]  start_state, start_addr;
    logic [6:0]  skip, dec;

    logic        rdy, mem_rd, olast, ovalid, busy, done;
    logic [5:0]  mem_addr, onb;
    logic [63:0] rdata;
    logic [31:0] odata;

    logic        rdy8, mem_rd8, olast8, ovalid8, busy8, done8;
    logic [5:0]  mem_addr8;
    logic [63:0] rdata8;
    logic [7:0]  odata8;
    logic [3:0]  onb8;

    logic [63:0] mem [64];
    logic [5:0]  rd_q[$], rd8_q[$];
    logic [63:0] x_q[$], x8_q[$];
    int done_n = 0, done8_n = 0;
    int n_chk = 0, n_err = 0;
    int c, bad, rd_stall, n_x, n_rd, n_d, n_x8, n_rd8, n_d8;

    tb_engine dut (
        .clk_i(clk), .rst_sync_i(rst), .start_i(start), .start_rdy_o(rdy),
        .cfg_m_i(cfg_m), .start_state_i(start_state), .start_addr_i(start_addr),
        .skip_len_i(skip), .dec_len_i(dec), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
        .mem_rdata_i(rdata), .out_data_o(odata), .out_nbits_o(onb), .out_last_o(olast),
        .out_valid_o(ovalid), .out_ready_i(ready), .busy_o(busy), .done_o(done)
    );

    tb_engine #(.W_OUT(8)) dut8 (
        .clk_i(clk), .rst_sync_i(rst), .start_i(start8), .start_rdy_o(rdy8),
        .cfg_m_i(cfg_m), .start_state_i(start_state), .start_addr_i(start_addr),
        .skip_len_i(skip), .dec_len_i(dec), .mem_rd_o(mem_rd8), .mem_addr_o(mem_addr8),
        .mem_rdata_i(rdata8), .out_data_o(odata8), .out_nbits_o(onb8), .out_last_o(olast8),
        .out_valid_o(ovalid8), .out_ready_i(ready8), .busy_o(busy8), .done_o(done8)
    );

    // Registered survivor memory plus transaction monitors.
    always @(posedge clk) begin
        if (mem_rd)  rdata  <= mem[mem_addr];
        if (mem_rd8) rdata8 <= mem[mem_addr8];
        if (!rst) begin
            if (mem_rd)  rd_q.push_back(mem_addr);
            if (mem_rd8) rd8_q.push_back(mem_addr8);
            if (ovalid && ready)   x_q.push_back(64'({olast, onb, odata}));
            if (ovalid8 && ready8) x8_q.push_back(64'({olast8, onb8, odata8}));
            if (done)  done_n++;
            if (done8) done8_n++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input bit w8, input logic [3:0] m, input logic [5:0] ss,
                      input logic [5:0] sa, input logic [6:0] sk, input logic [6:0] dl);
        @(negedge clk);
        check("start_rdy", 64'(w8 ? rdy8 : rdy), 64'd1);
        cfg_m = m; start_state = ss; start_addr = sa; skip = sk; dec = dl;
        if (w8) start8 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start8 = 1'b0;
        // Scramble config to show it was latched on acceptance.
        cfg_m = 4'd4; start_state = 6'h3F; start_addr = 6'h2A; skip = 7'd5; dec = 7'd9;
    endtask

    task automatic wait_valid(input int lim, output int cyc);
        cyc = 0;
        while (!ovalid && cyc < lim) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic wait_done(input bit w8, input int lim, input string tag);
        int k = 0;
        while (!(w8 ? done8 : done) && k < lim) begin @(posedge clk); #1; k++; end
        check(tag, 64'(w8 ? done8 : done), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic snap();
        n_x = x_q.size(); n_rd = rd_q.size(); n_d = done_n;
        n_x8 = x8_q.size(); n_rd8 = rd8_q.size(); n_d8 = done8_n;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; start8 = 1'b0; ready = 1'b1; ready8 = 1'b1;
        cfg_m = 4'd6; start_state = '0; start_addr = '0; skip = '0; dec = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (3) @(posedge clk); #1;
        check("reset_outs", 64'({ovalid, olast, onb, odata, mem_rd, mem_addr, busy, done}), 64'd0);
        check("reset_rdy", 64'({rdy, busy8, rdy8}), 64'b101);
        rst = 1'b0;

        // All-zero survivors: one full zero word, 72 cycles from start.
        snap();
        go(0, 4'd6, 6'd0, 6'd63, 7'd4, 7'd32);
        wait_valid(200, c);
        check("t30_latency", 64'(c), 64'd72);
        check("t30_word", 64'({olast, onb, odata}), 64'({1'b1, 6'd32, 32'h0}));
        wait_done(0, 50, "t30_done");
        check("t30_reads", 64'(rd_q.size() - n_rd), 64'd36);
        check("t30_xfers", 64'(x_q.size() - n_x), 64'd1);
        check("t30_done_cnt", 64'(done_n - n_d), 64'd1);

        // Reset in the middle of step 10.
        snap();
        go(0, 4'd6, 6'd0, 6'd63, 7'd0, 7'd64);
        repeat (18) @(posedge clk); #1;
        check("t34_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t34_outs", 64'({ovalid, olast, onb, odata, mem_rd, mem_addr, busy, done}), 64'd0);
        check("t34_rdy", 64'(rdy), 64'd1);
        rst = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("t34_no_done", 64'(done_n - n_d), 64'd0);
        check("t34_no_xfer", 64'(x_q.size() - n_x), 64'd0);

        // Address wrap and partial final word; bits 1,0,1.
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = '1; mem[62] = '1;
        snap();
        go(0, 4'd6, 6'd0, 6'd2, 7'd2, 7'd3);
        wait_done(0, 100, "t32_done");
        check("t32_reads", 64'(rd_q.size() - n_rd), 64'd5);
        check("t32_a0", 64'(rd_q[n_rd]),     64'd2);
        check("t32_a1", 64'(rd_q[n_rd + 1]), 64'd1);
        check("t32_a2", 64'(rd_q[n_rd + 2]), 64'd0);
        check("t32_a3", 64'(rd_q[n_rd + 3]), 64'd63);
        check("t32_a4", 64'(rd_q[n_rd + 4]), 64'd62);
        check("t32_word", x_q[n_x], 64'({1'b1, 6'd3, 32'h5}));

        // m=3, start 5, survivor bits set only at states 5..7.
        for (int i = 0; i < 64; i++) mem[i] = 64'hE0;
        snap();
        go(1, 4'd3, 6'd5, 6'd10, 7'd0, 7'd8);
        wait_done(1, 100, "t31_done");
        check("t31_reads", 64'(rd8_q.size() - n_rd8), 64'd8);
        for (int k = 0; k < 8; k++) check("t31_addr", 64'(rd8_q[n_rd8 + k]), 64'(10 - k));
        check("t31_word", x8_q[n_x8], 64'({1'b1, 4'd8, 8'hFF}));

        // Bit order: bits 1,1,0,0,0,0,0,0 | 0,0,1,0.
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[20] = '1; mem[19] = '1; mem[10] = '1;
        snap();
        go(1, 4'd3, 6'd0, 6'd20, 7'd0, 7'd12);
        wait_done(1, 100, "ord_done");
        check("ord_xfers", 64'(x8_q.size() - n_x8), 64'd2);
`ifdef TB_ENGINE_REVERSE_EN
        check("ord_w1", x8_q[n_x8],     64'({1'b0, 4'd8, 8'h03}));
        check("ord_w2", x8_q[n_x8 + 1], 64'({1'b1, 4'd4, 8'h04}));
`else
        check("ord_w1", x8_q[n_x8],     64'({1'b0, 4'd8, 8'hC0}));
        check("ord_w2", x8_q[n_x8 + 1], 64'({1'b1, 4'd4, 8'h02}));
`endif

        // skip+dec = 80 clamps to 64 steps, leaving 24 decoded bits.
        for (int i = 0; i < 64; i++) mem[i] = '0;
        snap();
        go(0, 4'd6, 6'd0, 6'd63, 7'd40, 7'd40);
        wait_done(0, 400, "clamp_done");
        check("clamp_reads", 64'(rd_q.size() - n_rd), 64'd64);
        check("clamp_word", x_q[n_x], 64'({1'b1, 6'd24, 32'h0}));

        // Backpressure: first word all ones, second all zeros.
        for (int i = 0; i < 64; i++) mem[i] = (i >= 32) ? '1 : '0;
        ready = 1'b0;
        snap();
        go(0, 4'd6, 6'd0, 6'd63, 7'd0, 7'd64);
        wait_valid(200, c);
        check("t33_first_lat", 64'(c), 64'd64);
        check("t33_word1", 64'({olast, onb, odata}), 64'({1'b0, 6'd32, 32'hFFFFFFFF}));
        bad = 0; rd_stall = 0;
        for (int i = 0; i < 90; i++) begin
            @(posedge clk); #1;
            if (!(ovalid && odata == 32'hFFFFFFFF && !olast)) bad++;
            if (i >= 70 && mem_rd) rd_stall++;
        end
        check("t33_stable", 64'(bad), 64'd0);
        check("t33_no_rd_stall", 64'(rd_stall), 64'd0);
        check("t33_reads_pre", 64'(rd_q.size() - n_rd), 64'd64);
        ready = 1'b1;
        wait_done(0, 50, "t33_done");
        check("t33_xfers", 64'(x_q.size() - n_x), 64'd2);
        check("t33_w1", x_q[n_x],     64'({1'b0, 6'd32, 32'hFFFFFFFF}));
        check("t33_w2", x_q[n_x + 1], 64'({1'b1, 6'd32, 32'h0}));
        check("t33_done_cnt", 64'(done_n - n_d), 64'd1);

        // Empty segment; start held high into the DONE cycle is ignored.
        snap();
        @(negedge clk);
        cfg_m = 4'd6; skip = 7'd0; dec = 7'd0; start = 1'b1;
        @(posedge clk); #1;
        check("t35_done", 64'({done, busy, rdy}), 64'b110);
        @(posedge clk); #1;
        check("t35_idle", 64'({done, busy, rdy}), 64'b001);
        start = 1'b0;
        @(posedge clk); #1;
        check("t35_stays_idle", 64'({done, busy, rdy}), 64'b001);
        check("t35_no_out", 64'(x_q.size() - n_x), 64'd0);
        check("t35_no_rd", 64'(rd_q.size() - n_rd), 64'd0);
        check("t35_done_cnt", 64'(done_n - n_d), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
